// File: rtl/sync_filter.sv
// Multi-channel input conditioner: N-stage synchronizer,
// stability filter and registered rise/fall edge pulses.
module sync_filter #(
  parameter int Channels     = 4,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 16,
  parameter logic [Channels-1:0] ResetValue = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Channels-1:0] data_i,
  output logic [Channels-1:0] data_o,
  output logic [Channels-1:0] rise_o,
  output logic [Channels-1:0] fall_o,
  output logic                changed_o
);

  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntLast =
    CntW'(FilterCycles - 1);

  if (SyncStages < 2) begin : g_bad_sync
    $error("SyncStages must be >= 2");
  end
  if (FilterCycles < 1) begin : g_bad_filt
    $error("FilterCycles must be >= 1");
  end

  logic [Channels-1:0] sync_q [SyncStages];
  logic [Channels-1:0] data_q;
  logic [Channels-1:0] rise_q;
  logic [Channels-1:0] fall_q;
  logic                changed_q;
  logic [CntW-1:0]     cnt_q [Channels];

  logic [Channels-1:0] s;
  logic [Channels-1:0] diff;
  logic [Channels-1:0] acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++)
        sync_q[i] <= ResetValue;
    end else begin
      sync_q[0] <= data_i;
      for (int i = 1; i < SyncStages; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SyncStages-1];

  // A channel flips only after its new level survived FilterCycles edges
  always_comb begin
    diff = s ^ data_q;
    acc  = '0;
    for (int c = 0; c < Channels; c++)
      acc[c] = diff[c] && (cnt_q[c] == CntLast);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= ResetValue;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int c = 0; c < Channels; c++)
        cnt_q[c] <= '0;
    end else begin
      data_q    <= data_q ^ acc;
      rise_q    <= acc & s;
      fall_q    <= acc & ~s;
      changed_q <= |acc;
      for (int c = 0; c < Channels; c++) begin
        unique case (1'b1)
          !diff[c]:           cnt_q[c] <= '0;
          acc[c]:             cnt_q[c] <= '0;
          diff[c] && !acc[c]: cnt_q[c] <= cnt_q[c] + 1'b1;
        endcase
      end
    end
  end

  assign data_o    = data_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter with an event scoreboard
// (Channels=4, SyncStages=3, FilterCycles=4, ResetValue=4'b1000).
module tb_sync_filter;

  localparam logic [3:0] RV = 4'b1000;
  localparam int LAT = 7;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] data_i = 4'hF;
  logic [3:0] data_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       changed_o;

  sync_filter #(
    .Channels    (4),
    .SyncStages  (3),
    .FilterCycles(4),
    .ResetValue  (RV)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] data;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] mon_data = RV;
  int         k;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic push_ev(input int c,
                         input logic [3:0] r,
                         input logic [3:0] f,
                         input logic [3:0] d);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.data = d;
    q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    ev_t e;
    if (rst_i) begin
      mon_data = RV;
    end else begin
      if (q.size() != 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("rise_o", rise_o, e.rise);
        chk("fall_o", fall_o, e.fall);
        chk("changed_o", changed_o, |(e.rise | e.fall));
        mon_data = e.data;
      end else begin
        chk("quiet", {rise_o, fall_o, changed_o}, 9'h0);
      end
      chk("data_o", data_o, mon_data);
    end
  end

  a_chg: assert property (@(posedge clk_i) disable iff (rst_i)
    $changed(data_o) |-> changed_o)
  else $error("FAIL changed_o: data_o moved without changed_o");

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with inputs all high, then quiet release
    wait_neg(10);
    chk("rst_data_o", data_o, RV);
    chk("rst_rise_o", rise_o, 4'h0);
    chk("rst_fall_o", fall_o, 4'h0);
    chk("rst_changed_o", changed_o, 1'b0);
    data_i = RV;
    rst_i  = 1'b0;
    wait_neg(20);

    // 2: single step on ch0
    k = cyc;
    data_i[0] = 1'b1;
    push_ev(k + LAT, 4'b0001, 4'b0000, 4'b1001);
    wait_neg(12);

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
    data_i[1] = 1'b1;
    wait_neg(3);
    data_i[1] = 1'b0;
    wait_neg(12);
    k = cyc;
    data_i[1] = 1'b1;
    push_ev(k + LAT, 4'b0010, 4'b0000, 4'b1011);
    wait_neg(4);
    data_i[1] = 1'b0;
    push_ev(k + 4 + LAT, 4'b0000, 4'b0010, 4'b1001);
    wait_neg(14);

    // 4: simultaneous rise on ch2 and fall on ch3
    k = cyc;
    data_i[2] = 1'b1;
    data_i[3] = 1'b0;
    push_ev(k + LAT, 4'b0100, 4'b1000, 4'b0101);
    wait_neg(12);

    // 5: async reset in the middle of a count
    k = cyc;
    data_i[1] = 1'b1;
    push_ev(k + LAT, 4'b0010, 4'b0000, 4'b0111);
    repeat (5) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    q.delete();
    #1;
    chk("midrst_data_o", data_o, RV);
    chk("midrst_pulses", {rise_o, fall_o, changed_o}, 9'h0);
    wait_neg(3);
    rst_i = 1'b0;
    k = cyc;
    push_ev(k + LAT, 4'b0111, 4'b1000, 4'b0111);
    wait_neg(12);

    // 6: chatter on ch0 never persists long enough
    repeat (50) begin
      data_i[0] = ~data_i[0];
      wait_neg(2);
    end
    wait_neg(20);
    chk("final_data_o", data_o, 4'b0111);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
